// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR loop filter.
//   PD_W  : phase-detector output width, shared with the MMPD.
//   sum_w : block-sum width for a given decimation factor. It is wide
//           enough that the sum cannot overflow.
//   sat_s : saturates a wide signed value to a w-bit signed range.
package cdr_pkg;

    localparam int PD_W = 16;

    function automatic int sum_w(input int decim);
        return PD_W + $clog2(decim);
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/cdr_lock_det.sv
// Lock detector for the CDR loop filter.
// A block is "quiet" when |blk| < LOCK_THRESH. The detector declares lock
// after LOCK_CNT consecutive quiet blocks, and drops lock on the first
// noisy block. The detector is only evaluated on blk_v cycles.
//   clk, rst : clock, synchronous active-high reset
//   blk      : signed block sum (SUM_W bits)
//   blk_v    : blk is valid this cycle
//   locked   : registered lock indicator
module cdr_lock_det
    import cdr_pkg::*;
#(
    parameter int SUM_W       = 19,
    parameter int LOCK_THRESH = 256,
    parameter int LOCK_CNT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [SUM_W-1:0] blk,
    input  logic                    blk_v,
    output logic                    locked
);

    localparam int LC_W = $clog2(LOCK_CNT + 1);

    logic [LC_W-1:0]         lcnt;
    logic [LC_W-1:0]         lcnt_n;
    logic signed [SUM_W:0]   blk_x;
    logic [SUM_W:0]          mag;
    logic                    quiet;

    // One extra bit so negating the most negative block sum is exact.
    always_comb begin
        blk_x  = (SUM_W+1)'(blk);
        mag    = blk_x[SUM_W] ? $unsigned(-blk_x) : $unsigned(blk_x);
        quiet  = (mag < $unsigned((SUM_W+1)'(LOCK_THRESH)));
        lcnt_n = '0;
        if (quiet)
            lcnt_n = (lcnt == LC_W'(LOCK_CNT)) ? lcnt : lcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt   <= '0;
            locked <= 1'b0;
        end else if (blk_v) begin
            lcnt   <= lcnt_n;
            locked <= (lcnt_n == LC_W'(LOCK_CNT));
        end
    end

endmodule

// File: rtl/cdr_loop_filter.sv
// Second-order CDR loop filter placed after the MMPD phase detector.
// The block decimates pd_err by summing DECIM accepted samples. It then
// applies a proportional path and a saturating integral path to each block
// sum, and adds the result into a wrapping phase accumulator. The top
// CODE_W bits of the accumulator form the phase-interpolator code.
//   clk, rst  : clock, synchronous active-high reset
//   pd_valid  : pd_err is valid this cycle
//   pd_err    : signed phase error f_n
//   freeze    : holds the integrator; sampled only in the update cycle
//   pi_code   : phase_acc[PH_W-1 -: CODE_W]
//   pi_valid  : one-cycle pulse after each update
//   int_out   : integrator value (frequency-offset estimate)
//   locked    : lock indicator
module cdr_loop_filter
    import cdr_pkg::*;
#(
    parameter int DECIM       = 8,
    parameter int KP_SHIFT    = 4,
    parameter int KI_SHIFT    = 10,
    parameter int INT_W       = 24,
    parameter int PH_W        = 16,
    parameter int CODE_W      = 7,
    parameter int LOCK_THRESH = 256,
    parameter int LOCK_CNT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pd_valid,
    input  logic signed [PD_W-1:0]  pd_err,
    input  logic                    freeze,
    output logic [CODE_W-1:0]       pi_code,
    output logic                    pi_valid,
    output logic signed [INT_W-1:0] int_out,
    output logic                    locked
);

    localparam int SUM_W = sum_w(DECIM);
    localparam int CNT_W = $clog2(DECIM);

    logic [CNT_W-1:0]         cnt;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_nxt;
    logic signed [SUM_W-1:0]  blk;
    logic                     blk_v;
    logic signed [INT_W-1:0]  int_q;
    logic [PH_W-1:0]          phase_acc;

    // The update math is carried out at 64 bits. That is wider than any
    // legal SUM_W+1 or INT_W+1, so nothing wraps until the final truncation
    // into the phase accumulator.
    logic signed [63:0] blk_w;
    logic signed [63:0] int_w;
    logic signed [63:0] int_n;
    logic signed [63:0] step;

    always_comb begin
        sum_nxt = sum + SUM_W'(pd_err);
        blk_w   = 64'(blk);
        int_w   = 64'(int_q);
        int_n   = freeze ? int_w : sat_s(int_w + (blk_w >>> KI_SHIFT), INT_W);
        step    = (blk_w >>> KP_SHIFT) + (int_n >>> (INT_W - 16));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sum       <= '0;
            blk       <= '0;
            blk_v     <= 1'b0;
            int_q     <= '0;
            phase_acc <= '0;
            pi_valid  <= 1'b0;
        end else begin
            // A block can never complete while blk_v is still high, because
            // DECIM >= 2. So the decimator and the update stage never compete.
            blk_v <= 1'b0;
            if (pd_valid) begin
                if (cnt == CNT_W'(DECIM - 1)) begin
                    blk   <= sum_nxt;
                    blk_v <= 1'b1;
                    sum   <= '0;
                    cnt   <= '0;
                end else begin
                    sum <= sum_nxt;
                    cnt <= cnt + 1'b1;
                end
            end
            if (blk_v) begin
                int_q     <= INT_W'(int_n);
                phase_acc <= phase_acc + PH_W'(step);
            end
            pi_valid <= blk_v;
        end
    end

    cdr_lock_det #(
        .SUM_W       (SUM_W),
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_CNT    (LOCK_CNT)
    ) u_lock (
        .clk    (clk),
        .rst    (rst),
        .blk    (blk),
        .blk_v  (blk_v),
        .locked (locked)
    );

    assign pi_code = phase_acc[PH_W-1 -: CODE_W];
    assign int_out = int_q;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Bench for cdr_loop_filter. It drives two instances with the same stimulus:
// one with default parameters, and one with INT_W=16 so that integrator
// saturation is reachable in a short run. A block-level reference model
// built from plain integer arithmetic predicts every output on every cycle.
module tb_cdr_loop_filter;

    logic               clk = 1'b0;
    logic               rst;
    logic               pd_valid;
    logic signed [15:0] pd_err;
    logic               freeze;

    logic [6:0]         pi_code,  pi_code16;
    logic               pi_valid, pi_valid16;
    logic signed [23:0] int_out;
    logic signed [15:0] int_out16;
    logic               locked,   locked16;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cdr_loop_filter dut (
        .clk(clk), .rst(rst), .pd_valid(pd_valid), .pd_err(pd_err), .freeze(freeze),
        .pi_code(pi_code), .pi_valid(pi_valid), .int_out(int_out), .locked(locked)
    );

    cdr_loop_filter #(.INT_W(16)) dut16 (
        .clk(clk), .rst(rst), .pd_valid(pd_valid), .pd_err(pd_err), .freeze(freeze),
        .pi_code(pi_code16), .pi_valid(pi_valid16), .int_out(int_out16), .locked(locked16)
    );

    // ---------------- reference model ----------------
    longint m_int [2];
    longint m_ph  [2];
    longint samp  [$];
    longint pblk;
    bit     pend;
    int     m_lcnt;
    bit     m_locked;
    bit     m_pv;

    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input int e, input bit f, input bit r);
        longint s, lim, n;
        int iw;
        if (r) begin
            for (int k = 0; k < 2; k++) begin m_int[k] = 0; m_ph[k] = 0; end
            samp.delete(); pend = 0; m_lcnt = 0; m_locked = 0; m_pv = 0;
            return;
        end
        m_pv = pend;
        if (pend) begin
            for (int k = 0; k < 2; k++) begin
                iw  = (k == 0) ? 24 : 16;
                lim = longint'(1) << (iw - 1);
                if (!f) begin
                    n = m_int[k] + fdiv(pblk, 1024);
                    if (n > lim - 1) n = lim - 1;
                    if (n < -lim)    n = -lim;
                    m_int[k] = n;
                end
                s = fdiv(pblk, 16) + fdiv(m_int[k], longint'(1) << (iw - 16));
                m_ph[k] = (((m_ph[k] + s) % 65536) + 65536) % 65536;
            end
            if ((pblk < 0 ? -pblk : pblk) < 256)
                m_lcnt = (m_lcnt < 16) ? m_lcnt + 1 : 16;
            else
                m_lcnt = 0;
            m_locked = (m_lcnt == 16);
            pend = 0;
        end
        if (v) begin
            samp.push_back(longint'(e));
            if (samp.size() == 8) begin
                pblk = 0;
                foreach (samp[i]) pblk += samp[i];
                samp.delete();
                pend = 1;
            end
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare #1 later.
    task automatic cyc(input bit v, input int e, input bit f, input bit r);
        rst = r; pd_valid = v; pd_err = 16'(e); freeze = f;
        @(posedge clk);
        model_edge(v, e, f, r);
        #1;
        chk("pi_valid",   longint'(pi_valid),   longint'(m_pv));
        chk("pi_code",    longint'(pi_code),    m_ph[0] >> 9);
        chk("int_out",    longint'(int_out),    m_int[0]);
        chk("locked",     longint'(locked),     longint'(m_locked));
        chk("pi_valid16", longint'(pi_valid16), longint'(m_pv));
        chk("pi_code16",  longint'(pi_code16),  m_ph[1] >> 9);
        chk("int_out16",  longint'(int_out16),  m_int[1]);
        chk("locked16",   longint'(locked16),   longint'(m_locked));
    endtask

    // Eight back-to-back samples, then the update cycle.
    task automatic blk8(input int e, input bit f);
        for (int i = 0; i < 8; i++) cyc(1, e, f, 0);
        cyc(0, 0, f, 0);
    endtask

    initial begin
        rst = 1; pd_valid = 0; pd_err = 0; freeze = 0;
        m_pv = 0; m_lcnt = 0; m_locked = 0; pend = 0; pblk = 0;
        for (int k = 0; k < 2; k++) begin m_int[k] = 0; m_ph[k] = 0; end

        // Reset with pd_valid toggling.
        for (int i = 0; i < 3; i++) cyc(i[0], 1000, 0, 1);
        chk("rst_pi_code",  longint'(pi_code),  0);
        chk("rst_int_out",  longint'(int_out),  0);
        chk("rst_pi_valid", longint'(pi_valid), 0);
        chk("rst_locked",   longint'(locked),   0);

        // Reset mid-block discards the partial sum.
        for (int i = 0; i < 5; i++) cyc(1, 1024, 0, 0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 1024, 0, 0);
        cyc(0, 0, 0, 0);
        chk("nocarry_pv",   longint'(pi_valid), 1);
        chk("nocarry_int",  longint'(int_out),  8);
        chk("basic_code",   longint'(pi_code),  1);

        // Gaps in pd_valid delay the update by the gap count.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1024, 0, 0);
            if (i == 3) begin cyc(0, 5, 0, 0); cyc(0, -7, 0, 0); end
        end
        cyc(0, 0, 0, 0);
        chk("gap_pv",   longint'(pi_valid), 1);
        chk("gap_int",  longint'(int_out),  8);
        chk("gap_code", longint'(pi_code),  1);

        // Negative step wraps the phase: 65536-513 = 65023, code 126.
        cyc(0, 0, 0, 1);
        blk8(-1024, 0);
        chk("wrap_int",  longint'(int_out), -8);
        chk("wrap_code", longint'(pi_code), 126);

        // Freeze holds the integrator; the proportional path keeps advancing.
        cyc(0, 0, 0, 1);
        blk8(1024, 0);
        blk8(1024, 1);
        blk8(1024, 1);
        chk("frz_int",  longint'(int_out), 8);
        chk("frz_code", longint'(pi_code), 3);

        // Lock after 16 quiet blocks, dropped by a block summing to 256.
        cyc(0, 0, 0, 1);
        for (int b = 0; b < 15; b++) blk8(0, 0);
        chk("lock_15", longint'(locked), 0);
        blk8(0, 0);
        chk("lock_16", longint'(locked), 1);
        blk8(32, 0);
        chk("unlock",  longint'(locked), 0);

        // Saturation, shown on the 16-bit integrator instance.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 150 * 8; i++) cyc(1, 32767, 0, 0);
        cyc(0, 0, 0, 0);
        chk("sat_hi16", longint'(int_out16), 32767);
        blk8(-32768, 0);
        chk("sat_dec16", longint'(int_out16), 32767 - 256);

        // Randomized traffic: gaps, freeze toggling, mixed amplitudes, rare resets.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 6000; i++) begin
            int e;
            case ($urandom_range(0, 3))
                0:       e = $urandom_range(0, 60) - 30;
                1:       e = $urandom_range(0, 65535) - 32768;
                2:       e = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                default: e = $urandom_range(0, 4000) - 2000;
            endcase
            cyc($urandom_range(0, 3) != 0, e, $urandom_range(0, 4) == 0,
                $urandom_range(0, 999) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdr_loop_filter.md
# cdr_loop_filter

Second-order digital CDR loop filter that sits directly downstream of the MMPD phase detector. It consumes the per-symbol signed phase-error stream `f_n`, decimates it by block summation, and applies a proportional + saturating-integral path. A wrapping phase accumulator drives the phase-interpolator code, and a lock indicator tracks error magnitude.

## Interface
Parameters:
- `DECIM`, 8: samples per block; power of 2, 2..64.
- `KP_SHIFT`, 4: proportional gain = 2^-KP_SHIFT, applied as an arithmetic right shift.
- `KI_SHIFT`, 10: integral gain = 2^-KI_SHIFT, applied as an arithmetic right shift.
- `INT_W`, 24: integrator width, signed, ≥16.
- `PH_W`, 16: phase accumulator width, unsigned, wrapping.
- `CODE_W`, 7: PI code width = top `CODE_W` bits of the phase accumulator.
- `LOCK_THRESH`, 256: lock window; a block counts as "quiet" when |block sum| < `LOCK_THRESH`.
- `LOCK_CNT`, 16: consecutive quiet blocks required to declare lock.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `pd_valid` in 1: `pd_err` is valid this cycle.
- `pd_err` in 16 signed: MMPD output `f_n`.
- `freeze` in 1: holds the integrator. The proportional path and phase accumulation continue.
- `pi_code` out CODE_W: phase-interpolator code, `phase_acc[PH_W-1 -: CODE_W]`.
- `pi_valid` out 1: one-cycle pulse when `pi_code`/`int_out` have just updated.
- `int_out` out INT_W signed: integrator value (frequency-offset estimate).
- `locked` out 1: lock indicator.

## Operation
- **Decimator:**
  - `cnt` counts accepted samples only; cycles with `pd_valid`=0 are ignored entirely.
  - `sum` accumulates `pd_err`, sign-extended to `SUM_W` = 16+log2(DECIM) bits. It cannot overflow.
  - On the valid sample where `cnt`==DECIM-1: `blk` <= `sum`+`pd_err`, `blk_v` <= 1, `sum` <= 0, `cnt` <= 0.
- **Update stage** (cycle where `blk_v`=1):
  - `int_n` = sat_INT_W(`int` + (`blk` >>> KI_SHIFT)). Saturate to [-2^(INT_W-1), 2^(INT_W-1)-1]; never wrap.
  - While `freeze`=1, `int_n` = `int`.
  - `step` = (`blk` >>> KP_SHIFT) + (`int_n` >>> (INT_W-16)), evaluated at ≥ SUM_W+1 bits, then truncated mod 2^PH_W.
  - `phase_acc` <= `phase_acc` + `step`, mod 2^PH_W. Wrap-around is intended (continuous PI rotation).
  - `int` <= `int_n`; `pi_valid` <= 1. Otherwise `pi_valid` <= 0.
- **Lock detector**, evaluated per `blk_v`:
  - |`blk`| < LOCK_THRESH: `lcnt` <= min(`lcnt`+1, LOCK_CNT).
  - Otherwise: `lcnt` <= 0.
  - `locked` = (`lcnt` == LOCK_CNT), registered. It updates on the same edge as `pi_code`.
  - |`blk`| uses SUM_W+1 bits, so the most negative value is handled correctly.
- **Reset:**
  - `sum`, `cnt`, `blk`, `blk_v`, `int`, `phase_acc`, `lcnt` = 0.
  - Outputs: `pi_code`=0, `pi_valid`=0, `int_out`=0, `locked`=0.
  - Reset mid-block discards the partial sum. A pending `blk_v` is cancelled, with no update.
- **Simultaneous events:** a block completing while `blk_v` is still high from the previous block cannot occur (DECIM ≥ 2). The new `pd_valid` sample is always accepted into the next block.
- **`freeze`:** sampled only in the update cycle. Toggling it mid-block has no other effect.

## Timing
- Final sample at edge E0 (`pd_valid`=1, `cnt`=DECIM-1) → `blk_v` high after E0.
- At E1: `int`, `phase_acc`, `pi_code`, `int_out`, `locked` update; `pi_valid` high for exactly one cycle after E1.
- Latency is 2 cycles from the final sample to the output. Sustained throughput is one `pd_err` per clock.
- No backpressure; every `pi_valid` is one update.

## Structure
- Shared `cdr_pkg` holds:
  - `PD_W`=16, the phase-detector output width shared with the MMPD.
  - The `sat_s` signed-saturation function.
  - `clog2`-based `SUM_W` derivation.
- Sub-module `cdr_lock_det` (inputs `blk`, `blk_v`; output `locked`; parameters `LOCK_THRESH`, `LOCK_CNT`). Decimator and PI path stay in the top.

## Test plan
All tests use defaults (DECIM=8, KP=4, KI=10, INT_W=24, PH_W=16, CODE_W=7).
1. **Reset:** assert `rst` 3 cycles with `pd_valid` toggling → `pi_code`=0, `int_out`=0, `pi_valid`=0, `locked`=0. Reset after 5 samples, then 8 samples of +1024 → first update shows `int_out`=8 (no carry-over).
2. **Basic step:** 8 valid samples of +1024 → `blk`=8192, `int_out`=8, `step`=512, `phase_acc`=512, `pi_code`=1. `pi_valid` pulses exactly 2 cycles after the 8th sample. Insert `pd_valid` gaps: same values, delayed by the gap count.
3. **Saturation:** +32767 continuously for ≥ 2^23/255 blocks → `int_out` pins at 8388607 and never goes negative. Then -32768 → it decrements from 8388607.
4. **Phase wrap:** from reset, 8 samples of -1024 → `int_out`=-8, `step`=-512-1=-513, `phase_acc`=65023, `pi_code`=126.
5. **Freeze:** `freeze`=1 with +1024 blocks → `int_out` is held at its prior value. `pi_code` keeps advancing by 512/block (plus the held integral term).
6. **Lock:** `pd_err`=0 for 16 blocks → `locked` rises with the 16th `pi_valid`. One block summing to 256 → `locked` falls with that block's `pi_valid`.
